// File: rtl/roc_count_sort_encoder_if.sv
// Bundle of the image-source and AER-side signals of the ROC encoder.
// The master side drives the image, control requests and the AER busy flag;
// the slave side (the encoder) returns the AER word stream and status.
interface roc_count_sort_encoder_if #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_BITS      = 8,
    parameter int AER_WIDTH       = 10
);
    logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE;
    logic                             NEW_IMAGE;
    logic                             ASCENDING;
    logic                             SKIP_ZERO;
    logic                             STOP;
    logic                             AERIN_CTRL_BUSY;
    logic [AER_WIDTH-1:0]             NEXT_INDEX;
    logic                             FOUND_NEXT_INDEX;
    logic                             ENCODER_RDY;
    logic [IMAGE_SIZE_BITS:0]         SPIKES_SENT;

    modport master (
        output IMAGE, NEW_IMAGE, ASCENDING, SKIP_ZERO, STOP, AERIN_CTRL_BUSY,
        input  NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, SPIKES_SENT
    );

    modport slave (
        input  IMAGE, NEW_IMAGE, ASCENDING, SKIP_ZERO, STOP, AERIN_CTRL_BUSY,
        output NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, SPIKES_SENT
    );
endinterface

// File: rtl/roc_count_sort_encoder.sv
// Rank-order-coding encoder built on a stable counting sort.
// Flow: capture image -> histogram -> exclusive prefix offsets (in place)
// -> place pixel indices into a rank memory -> stream a reset preamble
// followed by the sorted indices to the AER input controller.
module roc_count_sort_encoder #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_BITS      = 8,
    parameter int AER_WIDTH       = 10,
    parameter int AER_RST_WORDS   = 2,
    parameter int AER_RST_CODE    = 'h1FF
) (
    input logic CLK,
    input logic RST,
    roc_count_sort_encoder_if.slave bus
);
    localparam int B         = 2**PIXEL_BITS;
    localparam int CNT_BASE  = (IMAGE_SIZE_BITS > PIXEL_BITS) ? IMAGE_SIZE_BITS : PIXEL_BITS;
    localparam int CNT_W     = CNT_BASE + 1;
    localparam int HCNT_W    = IMAGE_SIZE_BITS + 1;
    localparam int PRE_W     = $clog2(AER_RST_WORDS + 1) + 1;

    localparam logic [CNT_W-1:0]     LAST_PIX = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [CNT_W-1:0]     LAST_BIN = CNT_W'(B - 1);
    localparam logic [PRE_W-1:0]     PRE_N    = PRE_W'(AER_RST_WORDS);
    localparam logic [HCNT_W-1:0]    N_FULL   = HCNT_W'(IMAGE_SIZE);
    localparam logic [AER_WIDTH-1:0] RST_WORD = AER_WIDTH'(AER_RST_CODE);

    typedef enum logic [2:0] {
        S_IDLE, S_HIST, S_PREFIX, S_PLACE, S_SEND, S_WAIT
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IMAGE_SIZE*PIXEL_BITS-1:0] image_q, image_d;
    logic                             asc_q, asc_d;
    logic                             skip_q, skip_d;
    logic [HCNT_W-1:0]                sum_q, sum_d;
    logic [HCNT_W-1:0]                hist0_q, hist0_d;
    logic [HCNT_W-1:0]                rank_q, rank_d;
    logic [HCNT_W-1:0]                hi_q, hi_d;
    logic [PRE_W-1:0]                 pre_q, pre_d;
    logic                             stop_pending_q, stop_pending_d;
    logic [AER_WIDTH-1:0]             next_index_q, next_index_d;
    logic                             found_q, found_d;
    logic                             rdy_q, rdy_d;
    logic [HCNT_W-1:0]                spikes_q, spikes_d;

    // Histogram doubles as the start-offset table after the prefix pass.
    logic [HCNT_W-1:0]          hist_mem [B];
    logic [IMAGE_SIZE_BITS-1:0] rank_mem [IMAGE_SIZE];

    logic [PIXEL_BITS-1:0]      pix_arr [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0]      pix_cur, bin_cur, hist_addr;
    logic [HCNT_W-1:0]          hist_rd, hist_wdata, hist0_eff;
    logic                       hist_we, hist_clr, place_wr, accept;
    logic [IMAGE_SIZE_BITS-1:0] rank_waddr, rank_wdata, rank_raddr, rank_rd;
    logic                       more_pre, more_pix, more, load;

    // Unpack the captured image into per-pixel lanes.
    always_comb begin
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            pix_arr[i] = image_q[i*PIXEL_BITS +: PIXEL_BITS];
        end
    end

    // Memory addressing, write data and the rank read with same-cycle bypass.
    always_comb begin
        accept     = (state_q == S_IDLE) && bus.NEW_IMAGE;
        place_wr   = (state_q == S_PLACE);
        pix_cur    = pix_arr[cnt_q[IMAGE_SIZE_BITS-1:0]];
        // Descending walk visits B-1..0, which is the bitwise inverse of the counter.
        bin_cur    = asc_q ? cnt_q[PIXEL_BITS-1:0] : ~cnt_q[PIXEL_BITS-1:0];
        hist_addr  = (state_q == S_PREFIX) ? bin_cur : pix_cur;
        hist_rd    = hist_mem[hist_addr];
        hist_we    = (state_q == S_HIST) || (state_q == S_PREFIX) || place_wr;
        hist_wdata = (state_q == S_PREFIX) ? sum_q : hist_rd + 1'b1;
        hist_clr   = RST || accept;
        hist0_eff  = (bin_cur == '0) ? hist_rd : hist0_q;
        rank_waddr = hist_rd[IMAGE_SIZE_BITS-1:0];
        rank_wdata = cnt_q[IMAGE_SIZE_BITS-1:0];
        rank_raddr = rank_q[IMAGE_SIZE_BITS-1:0];
        // The last PLACE write may land on the first rank to be sent.
        if (place_wr && (rank_waddr == rank_raddr)) begin
            rank_rd = rank_wdata;
        end else begin
            rank_rd = rank_mem[rank_raddr];
        end
        more_pre = (pre_q < PRE_N);
        more_pix = (rank_q < hi_q);
        more     = more_pre || more_pix;
    end

    // Next-state logic, per-image bookkeeping and AER word selection.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        image_d        = image_q;
        asc_d          = asc_q;
        skip_d         = skip_q;
        sum_d          = sum_q;
        hist0_d        = hist0_q;
        rank_d         = rank_q;
        hi_d           = hi_q;
        pre_d          = pre_q;
        stop_pending_d = stop_pending_q;
        next_index_d   = next_index_q;
        spikes_d       = spikes_q;
        load           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.NEW_IMAGE) begin
                    image_d        = bus.IMAGE;
                    asc_d          = bus.ASCENDING;
                    skip_d         = bus.SKIP_ZERO;
                    spikes_d       = '0;
                    cnt_d          = '0;
                    pre_d          = '0;
                    stop_pending_d = 1'b0;
                    state_d        = S_HIST;
                end
            end
            S_HIST: begin
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_PIX) begin
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_PREFIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PREFIX: begin
                sum_d = sum_q + hist_rd;
                if (bin_cur == '0) begin
                    hist0_d = hist_rd;
                end
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_BIN) begin
                    // Skipped zeros sit at the front (ascending) or back (descending).
                    rank_d  = (skip_q && asc_q) ? hist0_eff : '0;
                    hi_d    = (skip_q && !asc_q) ? N_FULL - hist0_eff : N_FULL;
                    cnt_d   = '0;
                    state_d = S_PLACE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PLACE: begin
                if (bus.STOP) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_PIX) begin
                    if (more) begin
                        load    = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (bus.STOP) begin
                    stop_pending_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.STOP) begin
                    stop_pending_d = 1'b1;
                end
                if (!bus.AERIN_CTRL_BUSY) begin
                    if (more && !stop_pending_q && !bus.STOP) begin
                        load    = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (more_pre) begin
                next_index_d = RST_WORD;
                pre_d        = pre_q + 1'b1;
            end else begin
                next_index_d = AER_WIDTH'(rank_rd);
                rank_d       = rank_q + 1'b1;
                spikes_d     = spikes_q + 1'b1;
            end
        end

        found_d = load;
        rdy_d   = (state_d == S_IDLE);
    end

    // State and output registers; reset covers control and visible outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            stop_pending_q <= 1'b0;
            next_index_q   <= '0;
            found_q        <= 1'b0;
            rdy_q          <= 1'b1;
            spikes_q       <= '0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            next_index_q   <= next_index_d;
            found_q        <= found_d;
            rdy_q          <= rdy_d;
            spikes_q       <= spikes_d;
        end
    end

    // Working registers of the sort; always initialised before use.
    always_ff @(posedge CLK) begin
        cnt_q   <= cnt_d;
        image_q <= image_d;
        asc_q   <= asc_d;
        skip_q  <= skip_d;
        sum_q   <= sum_d;
        hist0_q <= hist0_d;
        rank_q  <= rank_d;
        hi_q    <= hi_d;
        pre_q   <= pre_d;
    end

    // Histogram / offset table: bulk clear on reset and on image accept.
    always_ff @(posedge CLK) begin
        if (hist_clr) begin
            for (int b = 0; b < B; b++) begin
                hist_mem[b] <= '0;
            end
        end else if (hist_we) begin
            hist_mem[hist_addr] <= hist_wdata;
        end
    end

    // Rank memory: pixel index stored at its sorted position.
    always_ff @(posedge CLK) begin
        if (place_wr) begin
            rank_mem[rank_waddr] <= rank_wdata;
        end
    end

    assign bus.NEXT_INDEX       = next_index_q;
    assign bus.FOUND_NEXT_INDEX = found_q;
    assign bus.ENCODER_RDY      = rdy_q;
    assign bus.SPIKES_SENT      = spikes_q;
endmodule

// File: tb/tb_roc_count_sort_encoder.sv
// Bench for the ROC encoder: a small 8-pixel/3-bit instance and a default
// 256-pixel/8-bit instance. Expected AER words are queued when an image is
// issued; monitors pop and compare on every FOUND_NEXT_INDEX strobe.
module tb_roc_count_sort_encoder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    roc_count_sort_encoder_if #(.IMAGE_SIZE(8), .IMAGE_SIZE_BITS(3), .PIXEL_BITS(3), .AER_WIDTH(10)) bus_s ();
    roc_count_sort_encoder_if bus_d ();

    roc_count_sort_encoder #(
        .IMAGE_SIZE(8), .IMAGE_SIZE_BITS(3), .PIXEL_BITS(3),
        .AER_WIDTH(10), .AER_RST_WORDS(2), .AER_RST_CODE('h1FF)
    ) u_small (.CLK(clk), .RST(rst), .bus(bus_s));

    roc_count_sort_encoder u_dflt (.CLK(clk), .RST(rst), .bus(bus_d));

    logic [9:0] exp_s[$];
    logic [9:0] exp_d[$];
    int   acc_s, acc_d;
    bit   lat_s = 0, lat_d = 0;
    int   busy_len = 2;
    int   busy_left = 0;

    // pixels [3,7,0,7,1,5,5,2], pixel 0 in the low bits
    localparam logic [23:0] IMG1 = {3'd2, 3'd5, 3'd5, 3'd1, 3'd7, 3'd0, 3'd7, 3'd3};
    logic [9:0] v_desc [10] = '{10'h1FF, 10'h1FF, 10'd1, 10'd3, 10'd5, 10'd6, 10'd0, 10'd7, 10'd4, 10'd2};
    logic [9:0] v_asc  [9]  = '{10'h1FF, 10'h1FF, 10'd4, 10'd7, 10'd0, 10'd5, 10'd6, 10'd1, 10'd3};
    logic [9:0] v_stop [5]  = '{10'h1FF, 10'h1FF, 10'd1, 10'd3, 10'd5};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor, small instance.
    always @(negedge clk) begin
        if (bus_s.FOUND_NEXT_INDEX === 1'b1) begin
            if (exp_s.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_found_s: got word %0h expected no strobe", bus_s.NEXT_INDEX);
            end else begin
                check("word_s", 32'(bus_s.NEXT_INDEX), 32'(exp_s.pop_front()));
            end
            if (lat_s) begin
                check("latency_s", 32'(cyc - acc_s), 32'd24);
                lat_s = 0;
            end
        end
    end

    // Scoreboard monitor, default instance.
    always @(negedge clk) begin
        if (bus_d.FOUND_NEXT_INDEX === 1'b1) begin
            if (exp_d.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_found_d: got word %0h expected no strobe", bus_d.NEXT_INDEX);
            end else begin
                check("word_d", 32'(bus_d.NEXT_INDEX), 32'(exp_d.pop_front()));
            end
            if (lat_d) begin
                check("latency_d", 32'(cyc - acc_d), 32'd768);
                lat_d = 0;
            end
        end
    end

    // AER controller model for the small instance: busy for busy_len cycles per word.
    always @(negedge clk) begin
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus_s.AERIN_CTRL_BUSY = 1'b0;
        end
        if (bus_s.FOUND_NEXT_INDEX === 1'b1) begin
            bus_s.AERIN_CTRL_BUSY = 1'b1;
            busy_left = busy_len;
        end
    end

    task automatic start_s(input logic [23:0] img, input logic asc, input logic skip);
        @(negedge clk);
        bus_s.IMAGE     = img;
        bus_s.ASCENDING = asc;
        bus_s.SKIP_ZERO = skip;
        bus_s.NEW_IMAGE = 1'b1;
        @(negedge clk);
        bus_s.NEW_IMAGE = 1'b0;
        acc_s = cyc;
        lat_s = 1;
    endtask

    task automatic wait_rdy(input bit dflt, input int limit, input string name);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if ((dflt ? bus_d.ENCODER_RDY : bus_s.ENCODER_RDY) === 1'b1) break;
        end
        if (k == limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: ENCODER_RDY still low after %0d cycles, expected high", name, limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_s.IMAGE = '0; bus_s.NEW_IMAGE = 0; bus_s.ASCENDING = 0; bus_s.SKIP_ZERO = 0;
        bus_s.STOP = 0; bus_s.AERIN_CTRL_BUSY = 0;
        bus_d.IMAGE = '0; bus_d.NEW_IMAGE = 0; bus_d.ASCENDING = 0; bus_d.SKIP_ZERO = 0;
        bus_d.STOP = 0; bus_d.AERIN_CTRL_BUSY = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rdy", 32'(bus_s.ENCODER_RDY), 32'd1);
        check("rst_found", 32'(bus_s.FOUND_NEXT_INDEX), 32'd0);
        check("rst_next_index", 32'(bus_s.NEXT_INDEX), 32'd0);
        check("rst_spikes", 32'(bus_s.SPIKES_SENT), 32'd0);
        check("rst_rdy_d", 32'(bus_d.ENCODER_RDY), 32'd1);

        // Descending, no skip.
        foreach (v_desc[i]) exp_s.push_back(v_desc[i]);
        start_s(IMG1, 1'b0, 1'b0);
        wait_rdy(0, 300, "done_desc");
        check("drain_desc", 32'(exp_s.size()), 32'd0);
        check("spikes_desc", 32'(bus_s.SPIKES_SENT), 32'd8);

        // Ascending, zero suppression.
        foreach (v_asc[i]) exp_s.push_back(v_asc[i]);
        start_s(IMG1, 1'b1, 1'b1);
        wait_rdy(0, 300, "done_asc");
        check("drain_asc", 32'(exp_s.size()), 32'd0);
        check("spikes_asc", 32'(bus_s.SPIKES_SENT), 32'd7);

        // All-zero image with zero suppression: preamble only.
        exp_s.push_back(10'h1FF);
        exp_s.push_back(10'h1FF);
        start_s(24'd0, 1'b0, 1'b1);
        wait_rdy(0, 300, "done_zero");
        check("drain_zero", 32'(exp_s.size()), 32'd0);
        check("spikes_zero", 32'(bus_s.SPIKES_SENT), 32'd0);

        // NEW_IMAGE during PREFIX must be ignored.
        foreach (v_desc[i]) exp_s.push_back(v_desc[i]);
        start_s(IMG1, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        bus_s.IMAGE = 24'd0; bus_s.ASCENDING = 1'b1; bus_s.SKIP_ZERO = 1'b1;
        bus_s.NEW_IMAGE = 1'b1;
        @(negedge clk);
        bus_s.NEW_IMAGE = 1'b0;
        wait_rdy(0, 300, "done_newimg");
        check("drain_newimg", 32'(exp_s.size()), 32'd0);
        check("spikes_newimg", 32'(bus_s.SPIKES_SENT), 32'd8);

        // STOP during HIST: straight back to IDLE, nothing sent.
        start_s(IMG1, 1'b0, 1'b0);
        bus_s.STOP = 1'b1;
        @(negedge clk);
        bus_s.STOP = 1'b0;
        check("stop_hist_rdy", 32'(bus_s.ENCODER_RDY), 32'd1);
        repeat (40) @(negedge clk);
        check("stop_hist_spikes", 32'(bus_s.SPIKES_SENT), 32'd0);

        // STOP during WAIT of the third pixel index, BUSY high 5 cycles.
        busy_len = 5;
        foreach (v_stop[i]) exp_s.push_back(v_stop[i]);
        start_s(IMG1, 1'b0, 1'b0);
        begin
            int k;
            for (k = 0; k < 400; k++) begin
                @(negedge clk);
                if (bus_s.FOUND_NEXT_INDEX === 1'b1 && bus_s.SPIKES_SENT == 4'd3) break;
            end
            if (k == 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL stop_wait_reach: third index strobe not seen, expected within 400 cycles");
            end
        end
        @(negedge clk);
        bus_s.STOP = 1'b1;
        @(negedge clk);
        bus_s.STOP = 1'b0;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(posedge clk);
                if (bus_s.AERIN_CTRL_BUSY === 1'b0) break;
            end
        end
        @(negedge clk);
        check("stop_wait_rdy", 32'(bus_s.ENCODER_RDY), 32'd1);
        check("stop_wait_spikes", 32'(bus_s.SPIKES_SENT), 32'd3);
        check("stop_wait_drain", 32'(exp_s.size()), 32'd0);
        repeat (20) @(negedge clk);
        busy_len = 2;

        // Reset in the middle of PLACE.
        start_s(IMG1, 1'b1, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rdy", 32'(bus_s.ENCODER_RDY), 32'd1);
        check("midrst_found", 32'(bus_s.FOUND_NEXT_INDEX), 32'd0);
        check("midrst_next_index", 32'(bus_s.NEXT_INDEX), 32'd0);
        check("midrst_spikes", 32'(bus_s.SPIKES_SENT), 32'd0);
        repeat (40) @(negedge clk);
        check("midrst_idle", 32'(bus_s.ENCODER_RDY), 32'd1);
        foreach (v_desc[i]) exp_s.push_back(v_desc[i]);
        start_s(IMG1, 1'b0, 1'b0);
        wait_rdy(0, 300, "done_recover");
        check("drain_recover", 32'(exp_s.size()), 32'd0);
        check("spikes_recover", 32'(bus_s.SPIKES_SENT), 32'd8);

        // Default config, all pixels 255: preamble then 0..255 in order.
        exp_d.push_back(10'h1FF);
        exp_d.push_back(10'h1FF);
        for (int i = 0; i < 256; i++) exp_d.push_back(10'(i));
        @(negedge clk);
        bus_d.IMAGE = '1;
        bus_d.NEW_IMAGE = 1'b1;
        @(negedge clk);
        bus_d.NEW_IMAGE = 1'b0;
        acc_d = cyc;
        lat_d = 1;
        wait_rdy(1, 3000, "done_dflt");
        check("drain_dflt", 32'(exp_d.size()), 32'd0);
        check("spikes_dflt", 32'(bus_d.SPIKES_SENT), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
